hls_macc_nb_host: RTL and testbench

//  Initiator for the hls_macc_nb core's ap_ctrl_hs interface.
//  - Accepts one operand set (i1..i6) on a valid/ready stream.
//  - Drives the core's inputs and ap_start, and captures o1..o4 on their ap_vld strobes.
//  - Returns the four results plus error flags on a valid/ready stream.
//  - A watchdog flags a core that never completes, e.g. a locked core given a wrong key.

---
 rtl/hls_macc_nb_pkg.sv | 21 ++
 rtl/hls_macc_nb_watchdog.sv | 42 ++++
 rtl/hls_macc_nb_host.sv | 138 +++++++++++++
 tb/tb_hls_macc_nb_host.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_macc_nb_pkg.sv
// Shared definitions for the hls_macc_nb host-side initiator.
//   DW_DEFAULT       default operand/result width
//   NUM_IN, NUM_OUT  number of core operand and result words
//   ERR_VLD/ERR_TMO  bit positions inside out_err
//   state_e          host FSM states
package hls_macc_nb_pkg;

    localparam int unsigned DW_DEFAULT = 32;
    localparam int unsigned NUM_IN     = 6;
    localparam int unsigned NUM_OUT    = 4;

    localparam int unsigned ERR_VLD = 0;  // a result word never got its ap_vld strobe
    localparam int unsigned ERR_TMO = 1;  // core never signalled done

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StResp
    } state_e;

endpackage

// File: rtl/hls_macc_nb_watchdog.sv
// Launch-to-done watchdog.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clr_i          zero the count (takes priority over en_i)
//   en_i           count one cycle; saturates at TIMEOUT
//   expired_o      high in the enabled cycle whose closing edge brings the count to TIMEOUT
module hls_macc_nb_watchdog #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned     CntW      = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax    = CntW'(TIMEOUT);
    localparam logic [CntW-1:0] CntLast   = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Look one edge ahead so the owner can leave RUN on exactly the TIMEOUT-th edge.
    assign expired_o = en_i && (cnt_q >= CntLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hls_macc_nb_host.sv
// Initiator for the hls_macc_nb core's ap_ctrl_hs interface.
//   ap_clk, ap_rst_n        clock, asynchronous active-low reset (release expected sync to ap_clk)
//   in_valid/in_ready       operand stream, in_data = {i6..i1}
//   core_start/done/idle/ready  ap_ctrl_hs handshake to the core
//   core_i                  operands held to the core for the whole run
//   core_o, core_o_vld      result words and their per-word ap_vld strobes
//   out_valid/out_ready     result stream, out_data = {o4..o1}
//   out_err                 [ERR_VLD] missing strobe, [ERR_TMO] watchdog abort
//   busy                    FSM not idle
module hls_macc_nb_host
    import hls_macc_nb_pkg::*;
#(
    parameter int unsigned DW      = DW_DEFAULT,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_IN*DW-1:0]  in_data,
    output logic                  core_start,
    input  logic                  core_done,
    input  logic                  core_idle,
    input  logic                  core_ready,
    output logic [NUM_IN*DW-1:0]  core_i,
    input  logic [NUM_OUT*DW-1:0] core_o,
    input  logic [NUM_OUT-1:0]    core_o_vld,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NUM_OUT*DW-1:0] out_data,
    output logic [1:0]            out_err,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic                  core_start_q, core_start_d;
    logic [NUM_IN*DW-1:0]  core_i_q, core_i_d;
    logic [NUM_OUT*DW-1:0] cap_q, cap_d;
    logic [NUM_OUT-1:0]    mask_q, mask_d;
    logic [1:0]            err_q, err_d;
    logic                  wd_clr, wd_en, wd_expired;

    hls_macc_nb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (ap_clk),
        .rst_ni    (ap_rst_n),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        core_start_d = core_start_q;
        core_i_d     = core_i_q;
        cap_d        = cap_q;
        mask_d       = mask_q;
        err_d        = err_q;
        wd_clr       = 1'b0;
        wd_en        = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = core_idle;
                if (in_valid && core_idle) begin
                    core_i_d     = in_data;
                    cap_d        = '0;  // unstrobed words read back as zero
                    mask_d       = '0;
                    err_d        = '0;
                    wd_clr       = 1'b1;
                    core_start_d = 1'b1;
                    state_d      = StRun;
                end
            end
            StRun: begin
                wd_en = 1'b1;
                // Dropping start on ready keeps the core from relaunching when it goes idle.
                if (core_ready) begin
                    core_start_d = 1'b0;
                end
                for (int k = 0; k < NUM_OUT; k++) begin
                    if (core_o_vld[k]) begin
                        cap_d[k*DW +: DW] = core_o[k*DW +: DW];
                        mask_d[k]         = 1'b1;
                    end
                end
                // mask_d already includes strobes arriving alongside done.
                if (core_done) begin
                    err_d[ERR_VLD] = ~&mask_d;
                    err_d[ERR_TMO] = 1'b0;
                    state_d        = StResp;
                end else if (wd_expired) begin
                    err_d[ERR_VLD] = ~&mask_d;
                    err_d[ERR_TMO] = 1'b1;
                    core_start_d   = 1'b0;
                    state_d        = StResp;
                end
            end
            StResp: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= StIdle;
            core_start_q <= 1'b0;
            core_i_q     <= '0;
            cap_q        <= '0;
            mask_q       <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            core_start_q <= core_start_d;
            core_i_q     <= core_i_d;
            cap_q        <= cap_d;
            mask_q       <= mask_d;
            err_q        <= err_d;
        end
    end

    assign core_start = core_start_q;
    assign core_i     = core_i_q;
    assign out_data   = cap_q;
    assign out_err    = err_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_hls_macc_nb_host.sv
// Directed bench for hls_macc_nb_host with a behavioural ap_ctrl_hs core model.
// Model results: o1=i2*i6, o2=i1+i2*i6, o3=i3*i4+i5, o4=i1+..+i6.
module tb_hls_macc_nb_host;

    localparam int unsigned DW      = 32;
    localparam int unsigned TIMEOUT = 32;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [6*DW-1:0] in_data;
    logic            core_start;
    logic            core_done;
    logic            core_idle;
    logic            core_ready;
    logic [6*DW-1:0] core_i;
    logic [4*DW-1:0] core_o;
    logic [3:0]      core_o_vld;
    logic            out_valid;
    logic            out_ready;
    logic [4*DW-1:0] out_data;
    logic [1:0]      out_err;
    logic            busy;

    int errors = 0;
    int checks = 0;

    always #5 ap_clk = ~ap_clk;

    hls_macc_nb_host #(
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .core_start (core_start),
        .core_done  (core_done),
        .core_idle  (core_idle),
        .core_ready (core_ready),
        .core_i     (core_i),
        .core_o     (core_o),
        .core_o_vld (core_o_vld),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .busy       (busy)
    );

    // ---------------- core model ----------------
    logic            core_rst_n;
    logic [5:0]      m_step;
    logic [6*DW-1:0] m_in;
    logic [DW-1:0]   m_o1, m_o2, m_o3, m_o4;
    logic [3:0]      m_vld;
    logic            m_done;
    bit              hang;
    bit              sup_o3;
    logic [5:0]      done_at;
    int unsigned     launches = 0;
    logic            spur_done;
    logic            spur_vld;
    logic [DW-1:0]   spur_o1;

    always_ff @(posedge ap_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            m_step <= '0;
            m_in   <= '0;
        end else if (m_step == 6'd0) begin
            if (core_start) begin
                m_step <= 6'd1;
                m_in   <= core_i;
            end
        end else if (!hang && (m_step == done_at)) begin
            m_step <= 6'd0;
        end else if (m_step != 6'h3f) begin
            m_step <= m_step + 6'd1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (core_rst_n && (m_step == 6'd0) && core_start) begin
            launches <= launches + 1;
        end
    end

    always_comb begin
        m_o1     = m_in[DW +: DW] * m_in[5*DW +: DW];
        m_o2     = m_in[0 +: DW] + m_o1;
        m_o3     = m_in[2*DW +: DW] * m_in[3*DW +: DW] + m_in[4*DW +: DW];
        m_o4     = m_in[0 +: DW] + m_in[DW +: DW] + m_in[2*DW +: DW] + m_in[3*DW +: DW]
                 + m_in[4*DW +: DW] + m_in[5*DW +: DW];
        m_done   = !hang && (m_step == done_at);
        m_vld[0] = (m_step == 6'd2);
        m_vld[1] = (m_step == 6'd2);
        m_vld[2] = (m_step == 6'd5) && !sup_o3;
        m_vld[3] = m_done;
    end

    assign core_idle  = (m_step == 6'd0);
    assign core_ready = m_done;
    assign core_done  = m_done | spur_done;
    assign core_o_vld = m_vld | {3'b000, spur_vld};
    assign core_o     = {m_o4, m_o3, m_o2, spur_vld ? spur_o1 : m_o1};

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6*DW-1:0] pack6(input int a, input int b, input int c,
                                              input int d, input int e, input int f);
        return {DW'(f), DW'(e), DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    task automatic send(input string tag, input logic [6*DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Cycles from accept to out_valid, and the last of those cycles with core_start high.
    task automatic wait_out(output int n, output int start_hi);
        n        = 0;
        start_hi = -1;
        while (!out_valid && (n < 100)) begin
            tick();
            n++;
            if (core_start) start_hi = n;
        end
        if (!out_valid) check("wait_out_bound", 128'(out_valid), 128'(1));
    endtask

    task automatic check_res(input string tag, input int o1, input int o2, input int o3,
                             input int o4, input logic [1:0] err);
        check({tag, "_o1"}, 128'(out_data[0 +: DW]), 128'(DW'(o1)));
        check({tag, "_o2"}, 128'(out_data[DW +: DW]), 128'(DW'(o2)));
        check({tag, "_o3"}, 128'(out_data[2*DW +: DW]), 128'(DW'(o3)));
        check({tag, "_o4"}, 128'(out_data[3*DW +: DW]), 128'(DW'(o4)));
        check({tag, "_err"}, 128'(out_err), 128'(err));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n, sh;
        ap_rst_n   = 1'b0;
        core_rst_n = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        spur_done  = 1'b0;
        spur_vld   = 1'b0;
        spur_o1    = '0;
        hang       = 1'b0;
        sup_o3     = 1'b0;
        done_at    = 6'd6;
        repeat (2) @(posedge ap_clk);
        #1;
        check("rst_core_start", 128'(core_start), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_out_err", 128'(out_err), 128'(0));
        check("rst_core_i", 128'(core_i), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        ap_rst_n   = 1'b1;
        core_rst_n = 1'b1;
        tick();

        // 1: basic run
        send("t1", pack6(1, 2, 3, 4, 5, 6));
        check("t1_start_after_accept", 128'(core_start), 128'(1));
        check("t1_busy", 128'(busy), 128'(1));
        check("t1_core_i", 128'(core_i), 128'(pack6(1, 2, 3, 4, 5, 6)));
        wait_out(n, sh);
        check("t1_latency", 128'(n), 128'(7));
        check("t1_start_last_hi", 128'(sh), 128'(6));
        check("t1_start_low", 128'(core_start), 128'(0));
        check_res("t1", 12, 13, 17, 21, 2'b00);
        take();
        check("t1_valid_after_take", 128'(out_valid), 128'(0));
        check("t1_idle_after_take", 128'(busy), 128'(0));

        // 2: backpressure, then back-to-back sets
        send("t2a", pack6(2, 3, 4, 5, 6, 7));
        in_valid = 1'b1;
        in_data  = pack6(3, 1, 4, 1, 5, 9);
        check("t2a_core_i_held", 128'(core_i), 128'(pack6(2, 3, 4, 5, 6, 7)));
        wait_out(n, sh);
        check("t2a_latency", 128'(n), 128'(7));
        repeat (10) tick();
        check("t2a_stall_valid", 128'(out_valid), 128'(1));
        check("t2a_stall_in_ready", 128'(in_ready), 128'(0));
        check_res("t2a", 21, 23, 26, 27, 2'b00);
        take();
        check("t2b_in_ready", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        check("t2b_core_i", 128'(core_i), 128'(pack6(3, 1, 4, 1, 5, 9)));
        wait_out(n, sh);
        check("t2b_latency", 128'(n), 128'(7));
        check_res("t2b", 9, 12, 9, 23, 2'b00);
        take();
        check("t2_launches", 128'(launches), 128'(3));

        // 3: o3 strobe missing
        sup_o3 = 1'b1;
        send("t3", pack6(10, 20, 30, 40, 50, 60));
        wait_out(n, sh);
        check_res("t3", 1200, 1210, 0, 210, 2'b01);
        take();
        sup_o3 = 1'b0;

        // 4: core never completes
        hang = 1'b1;
        send("t4", pack6(1, 2, 3, 4, 5, 6));
        wait_out(n, sh);
        check("t4_timeout_latency", 128'(n), 128'(TIMEOUT));
        check("t4_start_forced_low", 128'(core_start), 128'(0));
        check_res("t4", 12, 13, 17, 0, 2'b11);
        take();
        in_valid = 1'b1;
        repeat (3) tick();
        check("t4_hung_in_ready", 128'(in_ready), 128'(0));
        check("t4_hung_busy", 128'(busy), 128'(0));
        in_valid   = 1'b0;
        core_rst_n = 1'b0;
        hang       = 1'b0;
        tick();
        core_rst_n = 1'b1;
        check("t4_core_reset_in_ready", 128'(in_ready), 128'(1));

        // 4b: done arrives on the same edge the watchdog expires
        done_at = 6'(TIMEOUT - 1);
        send("t4b", pack6(1, 2, 3, 4, 5, 6));
        wait_out(n, sh);
        check("t4b_latency", 128'(n), 128'(TIMEOUT));
        check_res("t4b", 12, 13, 17, 21, 2'b00);
        take();
        done_at = 6'd6;

        // 5: host reset mid-run
        send("t5", pack6(1, 2, 3, 4, 5, 6));
        repeat (3) tick();
        ap_rst_n   = 1'b0;
        core_rst_n = 1'b0;
        #1;
        check("t5_rst_core_start", 128'(core_start), 128'(0));
        check("t5_rst_core_i", 128'(core_i), 128'(0));
        check("t5_rst_out_data", 128'(out_data), 128'(0));
        check("t5_rst_busy", 128'(busy), 128'(0));
        check("t5_rst_out_valid", 128'(out_valid), 128'(0));
        tick();
        ap_rst_n   = 1'b1;
        core_rst_n = 1'b1;
        tick();
        send("t5b", pack6(1, 2, 3, 4, 5, 6));
        wait_out(n, sh);
        check("t5b_latency", 128'(n), 128'(7));
        check_res("t5b", 12, 13, 17, 21, 2'b00);
        take();

        // 6: spurious done / strobe while idle
        spur_done = 1'b1;
        spur_vld  = 1'b1;
        spur_o1   = 32'hdead_beef;
        repeat (2) tick();
        check("t6_no_valid", 128'(out_valid), 128'(0));
        check("t6_no_busy", 128'(busy), 128'(0));
        check("t6_o1_unchanged", 128'(out_data[0 +: DW]), 128'(12));
        check("t6_err_unchanged", 128'(out_err), 128'(0));
        spur_done = 1'b0;
        spur_vld  = 1'b0;
        send("t6b", pack6(2, 3, 4, 5, 6, 7));
        wait_out(n, sh);
        check_res("t6b", 21, 23, 26, 27, 2'b00);
        take();
        check("final_launches", 128'(launches), 128'(9));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
